// File: rtl/dma_pkg.sv
// Shared constants and helpers for the DMA AXI master: FSM state codes,
// AXI encodings and the chunk-size calculation.
package dma_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RADDR  = 3'd1;
  localparam logic [2:0] ST_RDATA  = 3'd2;
  localparam logic [2:0] ST_WADDR  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_WRESP  = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  // AXI encodings
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [2:0] SIZE_WORD      = 3'b010;

  // Bursts must not cross a 2^BOUNDARY_W byte boundary (4KB)
  localparam int BOUNDARY_W = 12;
  localparam logic [BOUNDARY_W:0] BOUNDARY_BYTES = {1'b1, {BOUNDARY_W{1'b0}}};

  // Beats for the next chunk: limited by words remaining, the burst cap and
  // the words left before either address reaches the next 4KB boundary.
  function automatic logic [4:0] chunk_beats(
    input logic [15:0]           remaining,
    input logic [BOUNDARY_W-1:0] src_off,
    input logic [BOUNDARY_W-1:0] dst_off,
    input logic [4:0]            max_burst
  );
    logic [BOUNDARY_W:0] src_words;
    logic [BOUNDARY_W:0] dst_words;
    logic [16:0]         beats;
    src_words = (BOUNDARY_BYTES - {1'b0, src_off}) >> 2;
    dst_words = (BOUNDARY_BYTES - {1'b0, dst_off}) >> 2;
    beats = {1'b0, remaining};
    if (beats > {12'd0, max_burst})     beats = {12'd0, max_burst};
    if ({4'd0, src_words} < beats)      beats = {4'd0, src_words};
    if ({4'd0, dst_words} < beats)      beats = {4'd0, dst_words};
    return beats[4:0];
  endfunction

endpackage

// File: rtl/dma_axi_master_if.sv
// AXI4 bus bundle between the DMA master and the interconnect.
interface dma_axi_master_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // read address
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [3:0]          ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  // read data
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;
  // write address
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [3:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  // write data
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  // write response
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/dma_burst_buffer.sv
// Chunk buffer: one entry per beat, written during the read burst and read
// back combinationally during the write burst.
module dma_burst_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // capture one read beat per accepted R handshake
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/dma_axi_master.sv
// DMA AXI4 master: copies LEN words from SRC to DST as a sequence of
// read-burst / write-burst chunks staged through a small buffer.
module dma_axi_master
  import dma_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int DMA_ID    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              error,
  dma_axi_master_if.master  axi
);
  localparam int         IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [4:0] MAX_B = 5'(MAX_BURST);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [15:0]       rem_q, rem_d;
  logic [4:0]        beats_q, beats_d;
  logic [4:0]        beat_q, beat_d;
  logic              rerr_q, rerr_d;
  logic              error_q, error_d;

  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic              last_beat;
  logic [ADDR_W-1:0] chunk_bytes;

  assign last_beat   = (beat_q == beats_q - 5'd1);
  assign chunk_bytes = ADDR_W'({beats_q, 2'b00});

  dma_burst_buffer #(
    .DEPTH (MAX_BURST),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clock    (clock),
    .wr_en_i  (buf_we),
    .wr_idx_i (beat_q[IDX_W-1:0]),
    .wr_data_i(axi.RDATA),
    .rd_idx_i (beat_q[IDX_W-1:0]),
    .rd_data_o(buf_rdata)
  );

  // next-state logic for the copy sequencer
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    rerr_d  = rerr_q;
    error_d = error_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (length != 16'd0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = length;
            beats_d = chunk_beats(length, src_addr[BOUNDARY_W-1:0],
                                  dst_addr[BOUNDARY_W-1:0], MAX_B);
            state_d = ST_RADDR;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RADDR: begin
        if (axi.ARREADY) begin
          beat_d  = 5'd0;
          rerr_d  = 1'b0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (axi.RVALID) begin
          buf_we = 1'b1;
          beat_d = beat_q + 5'd1;
          if (axi.RRESP != RESP_OKAY) rerr_d = 1'b1;
          // burst ends on RLAST or on the final counted beat; any mismatch
          // between the two, or a bad response, aborts the copy
          if (axi.RLAST || last_beat) begin
            if (axi.RLAST && last_beat && !rerr_q && axi.RRESP == RESP_OKAY) begin
              beat_d  = 5'd0;
              state_d = ST_WADDR;
            end else begin
              error_d = 1'b1;
              state_d = ST_FINISH;
            end
          end
        end
      end
      ST_WADDR: begin
        if (axi.AWREADY) state_d = ST_WDATA;
      end
      ST_WDATA: begin
        if (axi.WREADY) begin
          if (last_beat) state_d = ST_WRESP;
          else           beat_d  = beat_q + 5'd1;
        end
      end
      ST_WRESP: begin
        if (axi.BVALID) begin
          if (axi.BRESP != RESP_OKAY) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            src_d = src_q + chunk_bytes;
            dst_d = dst_q + chunk_bytes;
            rem_d = rem_q - {11'd0, beats_q};
            if (rem_d == 16'd0) begin
              state_d = ST_FINISH;
            end else begin
              beats_d = chunk_beats(rem_d, src_d[BOUNDARY_W-1:0],
                                    dst_d[BOUNDARY_W-1:0], MAX_B);
              state_d = ST_RADDR;
            end
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      beat_q  <= '0;
      rerr_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      rerr_q  <= rerr_d;
      error_q <= error_d;
    end
  end

  // all handshake outputs decode straight from state so reset drops them at once
  assign axi.ARID    = ID_W'(DMA_ID);
  assign axi.ARADDR  = src_q;
  assign axi.ARLEN   = 4'(beats_q - 5'd1);
  assign axi.ARSIZE  = SIZE_WORD;
  assign axi.ARBURST = AXI_BURST_INCR;
  assign axi.ARVALID = (state_q == ST_RADDR);
  assign axi.RREADY  = (state_q == ST_RDATA);

  assign axi.AWID    = ID_W'(DMA_ID);
  assign axi.AWADDR  = dst_q;
  assign axi.AWLEN   = 4'(beats_q - 5'd1);
  assign axi.AWSIZE  = SIZE_WORD;
  assign axi.AWBURST = AXI_BURST_INCR;
  assign axi.AWVALID = (state_q == ST_WADDR);

  assign axi.WDATA   = buf_rdata;
  assign axi.WSTRB   = '1;
  assign axi.WLAST   = (state_q == ST_WDATA) && last_beat;
  assign axi.WVALID  = (state_q == ST_WDATA);
  assign axi.BREADY  = (state_q == ST_WRESP);

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done  = (state_q == ST_FINISH);
  assign error = error_q;

  // response IDs are not needed: only one transaction is ever outstanding
  logic unused_ids;
  assign unused_ids = ^{axi.RID, axi.BID};
endmodule
